// File: rtl/voiceprint_pkg.sv
// Shared types and constants for the voiceprint mode controller.
// Imported by the sequencer and its read-port arbiter.
package voiceprint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_TRAIN   = 2'd2,
        ST_RECOG   = 2'd3
    } state_t;

    typedef enum logic {
        OP_TRAIN = 1'b0,
        OP_RECOG = 1'b1
    } op_t;

    localparam logic [4:0] CMD_TRAIN = 5'b01010;
    localparam logic [4:0] CMD_RECOG = 5'b01011;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_NO_SPK  = 2'd3;

endpackage

// File: rtl/voiceprint_sequencer_arbiter.sv
// MFCC buffer read-port arbiter: grant follows the registered state,
// and the 1-cycle-late valid returns to whichever requester issued the read.
module mfcc_port_arbiter
    import voiceprint_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  state_t            state,
    input  logic              trn_rd_req,
    input  logic [ADDR_W-1:0] trn_rd_addr,
    input  logic              rcg_rd_req,
    input  logic [ADDR_W-1:0] rcg_rd_addr,
    output logic              mfcc_rd_en,
    output logic [ADDR_W-1:0] mfcc_rd_addr,
    output logic              trn_rd_valid,
    output logic              rcg_rd_valid
);

    logic grant_trn;
    logic grant_rcg;

    assign grant_trn = (state == ST_TRAIN);
    assign grant_rcg = (state == ST_RECOG);

    // Put the grantee's request on the single buffer port; idle port reads address 0.
    always_comb begin
        mfcc_rd_en   = 1'b0;
        mfcc_rd_addr = '0;
        if (grant_trn) begin
            mfcc_rd_en   = trn_rd_req;
            mfcc_rd_addr = trn_rd_addr;
        end else if (grant_rcg) begin
            mfcc_rd_en   = rcg_rd_req;
            mfcc_rd_addr = rcg_rd_addr;
        end
    end

    // Buffer data lands one cycle later, so route the registered enable back.
    always_ff @(posedge clk) begin
        if (rst) begin
            trn_rd_valid <= 1'b0;
            rcg_rd_valid <= 1'b0;
        end else begin
            trn_rd_valid <= grant_trn & trn_rd_req;
            rcg_rd_valid <= grant_rcg & rcg_rd_req;
        end
    end

endmodule

// File: rtl/voiceprint_sequencer.sv
// Voiceprint mode controller: decodes host commands, sequences capture
// then train/recognize, tracks trained slots and reports results/errors.
module voiceprint_sequencer
    import voiceprint_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int MIN_FRAMES     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    output logic              capture_start,
    input  logic              mfcc_end,
    input  logic [8:0]        mfcc_number,
    output logic              train_start,
    output logic [2:0]        train_spk,
    input  logic              train_done,
    output logic              recog_start,
    input  logic              recog_done,
    input  logic [2:0]        recog_id,
    input  logic              trn_rd_req,
    input  logic [ADDR_W-1:0] trn_rd_addr,
    input  logic              rcg_rd_req,
    input  logic [ADDR_W-1:0] rcg_rd_addr,
    output logic              mfcc_rd_en,
    output logic [ADDR_W-1:0] mfcc_rd_addr,
    output logic              trn_rd_valid,
    output logic              rcg_rd_valid,
    output logic              busy,
    output logic [2:0]        result,
    output logic              result_valid,
    output logic [7:0]        trained_mask,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       MIN_N    = 9'(MIN_FRAMES);

    state_t           state;
    state_t           state_n;
    op_t              op;
    op_t              op_n;
    logic [CNT_W-1:0] wdog;
    logic             expired;
    logic             cap_n;
    logic             trs_n;
    logic             rcs_n;
    logic             rv_n;
    logic             err_n;
    logic [1:0]       code_n;
    logic [2:0]       spk_n;
    logic [2:0]       result_n;
    logic [7:0]       mask_n;

    assign busy    = (state != ST_IDLE);
    assign expired = busy && (wdog == CNT_LAST);

    // Next state and next values of every registered output.
    always_comb begin
        state_n  = state;
        op_n     = op;
        cap_n    = 1'b0;
        trs_n    = 1'b0;
        rcs_n    = 1'b0;
        rv_n     = 1'b0;
        err_n    = 1'b0;
        code_n   = err_code;
        spk_n    = train_spk;
        result_n = result;
        mask_n   = trained_mask;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_data[7:3] == CMD_TRAIN) begin
                    spk_n   = cmd_data[2:0];
                    op_n    = OP_TRAIN;
                    cap_n   = 1'b1;
                    state_n = ST_CAPTURE;
                end else if (cmd_valid && cmd_data[7:3] == CMD_RECOG) begin
                    if (trained_mask == 8'h00) begin
                        err_n  = 1'b1;
                        code_n = ERR_NO_SPK;
                    end else begin
                        op_n    = OP_RECOG;
                        cap_n   = 1'b1;
                        state_n = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (mfcc_end) begin
                    if (mfcc_number < MIN_N) begin
                        err_n   = 1'b1;
                        code_n  = ERR_SHORT;
                        state_n = ST_IDLE;
                    end else if (op == OP_RECOG) begin
                        rcs_n   = 1'b1;
                        state_n = ST_RECOG;
                    end else begin
                        trs_n   = 1'b1;
                        state_n = ST_TRAIN;
                    end
                end else if (expired) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (train_done) begin
                    mask_n  = trained_mask | (8'h01 << train_spk);
                    state_n = ST_IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                end
            end
            ST_RECOG: begin
                if (recog_done) begin
                    result_n = recog_id;
                    rv_n     = 1'b1;
                    state_n  = ST_IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and registered pulse/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            op            <= OP_TRAIN;
            capture_start <= 1'b0;
            train_start   <= 1'b0;
            recog_start   <= 1'b0;
            result_valid  <= 1'b0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            train_spk     <= 3'd0;
            result        <= 3'd0;
            trained_mask  <= 8'h00;
        end else begin
            state         <= state_n;
            op            <= op_n;
            capture_start <= cap_n;
            train_start   <= trs_n;
            recog_start   <= rcs_n;
            result_valid  <= rv_n;
            err           <= err_n;
            err_code      <= code_n;
            train_spk     <= spk_n;
            result        <= result_n;
            trained_mask  <= mask_n;
        end
    end

    // Per-phase watchdog: restarts on every state change, idles at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state_n != state || state == ST_IDLE) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    mfcc_port_arbiter #(
        .ADDR_W(ADDR_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .trn_rd_req  (trn_rd_req),
        .trn_rd_addr (trn_rd_addr),
        .rcg_rd_req  (rcg_rd_req),
        .rcg_rd_addr (rcg_rd_addr),
        .mfcc_rd_en  (mfcc_rd_en),
        .mfcc_rd_addr(mfcc_rd_addr),
        .trn_rd_valid(trn_rd_valid),
        .rcg_rd_valid(rcg_rd_valid)
    );

endmodule

// File: tb/tb_voiceprint_sequencer.sv
// Bench for voiceprint_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_voiceprint_sequencer;

    localparam int AW  = 14;
    localparam int MIN = 8;
    localparam int TO  = 100;

    localparam int P_IDLE = 0;
    localparam int P_CAP  = 1;
    localparam int P_TRN  = 2;
    localparam int P_RCG  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [7:0]    cmd_data;
    logic          capture_start;
    logic          mfcc_end;
    logic [8:0]    mfcc_number;
    logic          train_start;
    logic [2:0]    train_spk;
    logic          train_done;
    logic          recog_start;
    logic          recog_done;
    logic [2:0]    recog_id;
    logic          trn_rd_req;
    logic [AW-1:0] trn_rd_addr;
    logic          rcg_rd_req;
    logic [AW-1:0] rcg_rd_addr;
    logic          mfcc_rd_en;
    logic [AW-1:0] mfcc_rd_addr;
    logic          trn_rd_valid;
    logic          rcg_rd_valid;
    logic          busy;
    logic [2:0]    result;
    logic          result_valid;
    logic [7:0]    trained_mask;
    logic          err;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         m_phase = P_IDLE;
    bit         m_recog = 1'b0;
    int         cyc_no  = 0;
    int         t0      = 0;
    logic [2:0] m_spk   = 3'd0;
    logic [7:0] m_mask  = 8'h00;
    logic [2:0] m_res   = 3'd0;
    logic [1:0] m_code  = 2'd0;
    logic       m_cap   = 1'b0;
    logic       m_trs   = 1'b0;
    logic       m_rcs   = 1'b0;
    logic       m_rv    = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_trn_v = 1'b0;
    logic       m_rcg_v = 1'b0;

    logic          exp_en;
    logic [AW-1:0] exp_addr;

    voiceprint_sequencer #(
        .ADDR_W(AW),
        .MIN_FRAMES(MIN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .capture_start(capture_start),
        .mfcc_end     (mfcc_end),
        .mfcc_number  (mfcc_number),
        .train_start  (train_start),
        .train_spk    (train_spk),
        .train_done   (train_done),
        .recog_start  (recog_start),
        .recog_done   (recog_done),
        .recog_id     (recog_id),
        .trn_rd_req   (trn_rd_req),
        .trn_rd_addr  (trn_rd_addr),
        .rcg_rd_req   (rcg_rd_req),
        .rcg_rd_addr  (rcg_rd_addr),
        .mfcc_rd_en   (mfcc_rd_en),
        .mfcc_rd_addr (mfcc_rd_addr),
        .trn_rd_valid (trn_rd_valid),
        .rcg_rd_valid (rcg_rd_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .trained_mask (trained_mask),
        .err          (err),
        .err_code     (err_code)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic enter(input int p);
        m_phase = p;
        t0      = cyc_no;
    endtask

    task automatic raise(input logic [1:0] code);
        m_err   = 1'b1;
        m_code  = code;
        m_phase = P_IDLE;
    endtask

    // Predict outputs after the coming rising edge from the inputs it will sample.
    task automatic model_advance();
        bit expired;
        cyc_no++;
        m_cap = 1'b0;
        m_trs = 1'b0;
        m_rcs = 1'b0;
        m_rv  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_phase = P_IDLE;
            m_recog = 1'b0;
            m_spk   = 3'd0;
            m_mask  = 8'h00;
            m_res   = 3'd0;
            m_code  = 2'd0;
            m_trn_v = 1'b0;
            m_rcg_v = 1'b0;
        end else begin
            m_trn_v = (m_phase == P_TRN) && trn_rd_req;
            m_rcg_v = (m_phase == P_RCG) && rcg_rd_req;
            expired = (m_phase != P_IDLE) && (cyc_no - t0 == TO);
            case (m_phase)
                P_IDLE: begin
                    if (cmd_valid && cmd_data[7:3] == 5'b01010) begin
                        m_spk   = cmd_data[2:0];
                        m_recog = 1'b0;
                        m_cap   = 1'b1;
                        enter(P_CAP);
                    end else if (cmd_valid && cmd_data[7:3] == 5'b01011) begin
                        if (m_mask == 8'h00) begin
                            raise(2'd3);
                        end else begin
                            m_recog = 1'b1;
                            m_cap   = 1'b1;
                            enter(P_CAP);
                        end
                    end
                end
                P_CAP: begin
                    if (mfcc_end) begin
                        if (int'(mfcc_number) < MIN) begin
                            raise(2'd1);
                        end else if (m_recog) begin
                            m_rcs = 1'b1;
                            enter(P_RCG);
                        end else begin
                            m_trs = 1'b1;
                            enter(P_TRN);
                        end
                    end else if (expired) begin
                        raise(2'd2);
                    end
                end
                P_TRN: begin
                    if (train_done) begin
                        m_mask[m_spk] = 1'b1;
                        m_phase = P_IDLE;
                    end else if (expired) begin
                        raise(2'd2);
                    end
                end
                default: begin
                    if (recog_done) begin
                        m_res   = recog_id;
                        m_rv    = 1'b1;
                        m_phase = P_IDLE;
                    end else if (expired) begin
                        raise(2'd2);
                    end
                end
            endcase
        end
    endtask

    // Every falling edge: compare DUT to model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_en   = 1'b0;
            exp_addr = '0;
            if (m_phase == P_TRN) begin
                exp_en   = trn_rd_req;
                exp_addr = trn_rd_addr;
            end else if (m_phase == P_RCG) begin
                exp_en   = rcg_rd_req;
                exp_addr = rcg_rd_addr;
            end
            chk("capture_start", 32'(capture_start), 32'(m_cap));
            chk("train_start", 32'(train_start), 32'(m_trs));
            chk("recog_start", 32'(recog_start), 32'(m_rcs));
            chk("train_spk", 32'(train_spk), 32'(m_spk));
            chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
            chk("result", 32'(result), 32'(m_res));
            chk("result_valid", 32'(result_valid), 32'(m_rv));
            chk("trained_mask", 32'(trained_mask), 32'(m_mask));
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("trn_rd_valid", 32'(trn_rd_valid), 32'(m_trn_v));
            chk("rcg_rd_valid", 32'(rcg_rd_valid), 32'(m_rcg_v));
            chk("mfcc_rd_en", 32'(mfcc_rd_en), 32'(exp_en));
            chk("mfcc_rd_addr", 32'(mfcc_rd_addr), 32'(exp_addr));
        end
        model_advance();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cyc();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic end_capture(input logic [8:0] n);
        mfcc_end    = 1'b1;
        mfcc_number = n;
        cyc();
        mfcc_end    = 1'b0;
        mfcc_number = 9'd0;
    endtask

    // Directed scenarios, then randomized traffic.
    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        mfcc_end    = 1'b0;
        mfcc_number = 9'd0;
        train_done  = 1'b0;
        recog_done  = 1'b0;
        recog_id    = 3'd0;
        trn_rd_req  = 1'b0;
        trn_rd_addr = '0;
        rcg_rd_req  = 1'b0;
        rcg_rd_addr = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mask", 32'(trained_mask), 32'h00);
        chk("rst_code", 32'(err_code), 32'd0);

        send_cmd(8'h58);
        chk("nospk_err", 32'(err), 32'd1);
        chk("nospk_code", 32'(err_code), 32'd3);
        chk("nospk_cap", 32'(capture_start), 32'd0);
        chk("nospk_busy", 32'(busy), 32'd0);
        cyc();
        chk("nospk_pulse", 32'(err), 32'd0);

        send_cmd(8'h52);
        chk("trn_cap", 32'(capture_start), 32'd1);
        chk("trn_busy", 32'(busy), 32'd1);
        chk("trn_spk", 32'(train_spk), 32'd2);
        repeat (5) cyc();
        end_capture(9'd40);
        chk("trn_start", 32'(train_start), 32'd1);
        repeat (50) cyc();
        train_done = 1'b1;
        cyc();
        train_done = 1'b0;
        chk("trn_mask", 32'(trained_mask), 32'h04);
        chk("trn_idle", 32'(busy), 32'd0);

        send_cmd(8'h58);
        chk("rcg_cap", 32'(capture_start), 32'd1);
        end_capture(9'd40);
        chk("rcg_start", 32'(recog_start), 32'd1);
        trn_rd_req  = 1'b1;
        trn_rd_addr = 14'h2AA;
        #1;
        chk("rcg_trn_en", 32'(mfcc_rd_en), 32'd0);
        cyc();
        trn_rd_req = 1'b0;
        chk("rcg_trn_valid", 32'(trn_rd_valid), 32'd0);
        rcg_rd_req  = 1'b1;
        rcg_rd_addr = 14'h123;
        #1;
        chk("rcg_en", 32'(mfcc_rd_en), 32'd1);
        chk("rcg_addr", 32'(mfcc_rd_addr), 32'h123);
        cyc();
        rcg_rd_req = 1'b0;
        chk("rcg_valid", 32'(rcg_rd_valid), 32'd1);
        recog_done = 1'b1;
        recog_id   = 3'd2;
        cyc();
        recog_done = 1'b0;
        recog_id   = 3'd0;
        chk("rcg_result", 32'(result), 32'd2);
        chk("rcg_rv", 32'(result_valid), 32'd1);
        cyc();
        chk("rcg_rv_pulse", 32'(result_valid), 32'd0);

        send_cmd(8'h55);
        end_capture(9'd5);
        chk("short_err", 32'(err), 32'd1);
        chk("short_code", 32'(err_code), 32'd1);
        chk("short_busy", 32'(busy), 32'd0);
        chk("short_mask", 32'(trained_mask), 32'h04);

        send_cmd(8'h53);
        end_capture(9'd40);
        repeat (99) cyc();
        chk("wd_early", 32'(err), 32'd0);
        chk("wd_busy", 32'(busy), 32'd1);
        cyc();
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_code", 32'(err_code), 32'd2);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_mask", 32'(trained_mask), 32'h04);

        send_cmd(8'h53);
        end_capture(9'd40);
        repeat (99) cyc();
        train_done = 1'b1;
        cyc();
        train_done = 1'b0;
        chk("wdd_err", 32'(err), 32'd0);
        chk("wdd_mask", 32'(trained_mask), 32'h0C);

        send_cmd(8'h58);
        end_capture(9'd40);
        rcg_rd_req  = 1'b1;
        rcg_rd_addr = 14'h123;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mask", 32'(trained_mask), 32'h00);
        chk("rst_mid_res", 32'(result), 32'd0);
        chk("rst_mid_en", 32'(mfcc_rd_en), 32'd0);
        chk("rst_mid_val", 32'(rcg_rd_valid), 32'd0);
        rcg_rd_req = 1'b0;
        cyc();

        for (int i = 0; i < 4000; i++) begin
            int sel;
            rst       = ($urandom_range(0, 599) == 0);
            cmd_valid = ($urandom_range(0, 14) == 0);
            sel       = $urandom_range(0, 2);
            if (sel == 0)
                cmd_data = 8'h50 | 8'($urandom_range(0, 7));
            else if (sel == 1)
                cmd_data = 8'h58 | 8'($urandom_range(0, 7));
            else
                cmd_data = 8'($urandom);
            mfcc_end    = ($urandom_range(0, 19) == 0);
            mfcc_number = ($urandom_range(0, 1) == 1)
                          ? 9'($urandom_range(0, 15)) : 9'd40;
            train_done  = ($urandom_range(0, 39) == 0);
            recog_done  = ($urandom_range(0, 39) == 0);
            recog_id    = 3'($urandom);
            trn_rd_req  = 1'($urandom);
            trn_rd_addr = 14'($urandom);
            rcg_rd_req  = 1'($urandom);
            rcg_rd_addr = 14'($urandom);
            cyc();
        end
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        mfcc_end   = 1'b0;
        train_done = 1'b0;
        recog_done = 1'b0;
        trn_rd_req = 1'b0;
        rcg_rd_req = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
